// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the cpu (port 0) and the debug probe (port 1).
// Build option MEM_ARB_RR_EN selects round-robin arbitration; without it port 1 has fixed priority.
//
// state  | meaning
// IDLE   | waiting for a request; grant is issued in this cycle and the request latched
// ACCESS | RAM strobed with the latched address/data/we
// RESP   | RAM read data returned to the owner, done pulsed

module mem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        gnt,
   output logic [1:0]        done,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              ram_we,
   output logic              ram_cs,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              owner;
   logic              we_q;
   logic              win;
   logic              grant_en;
   logic              resp_en;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;
`ifdef MEM_ARB_RR_EN
   logic              last_winner;
`endif

   always_comb begin
      win = req[1];
`ifdef MEM_ARB_RR_EN
      if (req == 2'b11) win = ~last_winner;
`endif
   end

   // grant and done are gated by reset so a request held through reset is never accepted
   always_comb begin
      state_nxt = state;
      grant_en  = rst && (state == IDLE) && (req != 2'b00);
      resp_en   = rst && (state == RESP);
      case (state)
         IDLE:    if (grant_en) state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      gnt       = grant_en ? (win ? 2'b10 : 2'b01) : 2'b00;
      done      = resp_en ? (owner ? 2'b10 : 2'b01) : 2'b00;
      ram_cs    = (state == ACCESS);
      ram_we    = (state == ACCESS) && we_q;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      rdata0    = (resp_en && !we_q && !owner) ? ram_rdata : rdata0_q;
      rdata1    = (resp_en && !we_q && owner) ? ram_rdata : rdata1_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         owner    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
`ifdef MEM_ARB_RR_EN
         last_winner <= 1'b1;
`endif
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         if (grant_en) begin
            owner   <= win;
            we_q    <= win ? we[1] : we[0];
            addr_q  <= win ? addr1 : addr0;
            wdata_q <= win ? wdata1 : wdata0;
`ifdef MEM_ARB_RR_EN
            last_winner <= win;
`endif
         end
         if ((state == RESP) && !we_q) begin
            if (owner) rdata1_q <= ram_rdata;
            else       rdata0_q <= ram_rdata;
         end
      end
   end

   a_single_owner: assert property (@(posedge clk) disable iff (!rst)
      !(&gnt) && !(&done));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural sync RAM, scoreboard of expected completions,
// and cycle logs of grants / RAM strobes / done pulses for timing checks.
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req;
   logic [1:0] we;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic [1:0] gnt, done;
   logic [7:0] rdata0, rdata1, ram_addr, ram_wdata, ram_rdata;
   logic       ram_we, ram_cs, busy;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt(gnt), .done(done), .rdata0(rdata0), .rdata1(rdata1),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .ram_we(ram_we), .ram_cs(ram_cs), .busy(busy)
   );

   logic [7:0] ram_mem [0:255];
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= ram_mem[ram_addr];
      end
   end

   typedef struct {
      int         port;
      bit         w;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   gnt_cyc[$];
   int   gnt_port[$];
   int   cs_cyc[$];
   int   done_cyc[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   logic       cs_we_last;
   logic [7:0] cs_addr_last, cs_wdata_last;

   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard pop and event logging, sampled mid-cycle
   exp_t       e;
   logic [1:0] expd;
   logic [7:0] got;
   always @(negedge clk) begin
      if (gnt[0]) begin gnt_cyc.push_back(cyc); gnt_port.push_back(0); end
      if (gnt[1]) begin gnt_cyc.push_back(cyc); gnt_port.push_back(1); end
      if (ram_cs) begin
         cs_cyc.push_back(cyc);
         cs_we_last    = ram_we;
         cs_addr_last  = ram_addr;
         cs_wdata_last = ram_wdata;
      end
      if (done != 2'b00) begin
         done_cnt++;
         done_cyc.push_back(cyc);
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_done: done=%b with no access outstanding", done);
         end else begin
            e    = sb.pop_front();
            expd = 2'b01 << e.port;
            if (done !== expd) begin
               errors++;
               $display("FAIL sb_done_port: done=%b want %b", done, expd);
            end else if (!e.w) begin
               checks++;
               got = e.port ? rdata1 : rdata0;
               if (got !== e.data) begin
                  errors++;
                  $display("FAIL sb_rdata%0d: got %h want %h", e.port, got, e.data);
               end
            end
         end
      end
   end

   task automatic push_exp(input int p, input bit w, input logic [7:0] d);
      exp_t x;
      x.port = p; x.w = w; x.data = d;
      sb.push_back(x);
   endtask

   task automatic clear_logs();
      gnt_cyc.delete(); gnt_port.delete(); cs_cyc.delete(); done_cyc.delete();
   endtask

   task automatic drive_req(input int p, input bit w, input logic [7:0] a, input logic [7:0] d);
      if (p == 0) begin we[0] = w; addr0 = a; wdata0 = d; req[0] = 1'b1; end
      else        begin we[1] = w; addr1 = a; wdata1 = d; req[1] = 1'b1; end
   endtask

   task automatic wait_gnt(input int p, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gnt[p]) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
   endtask

   task automatic access(input int p, input bit w, input logic [7:0] a, input logic [7:0] d,
                         output bit ok);
      @(posedge clk); #1;
      drive_req(p, w, a, d);
      wait_gnt(p, ok);
      @(posedge clk); #1;
      req[p] = 1'b0;
   endtask

   task automatic wait_done(input int tgt, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (done_cnt >= tgt) begin ok = 1'b1; break; end
         @(negedge clk); #1;
      end
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst = 1'b0; req = 2'b00;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; req = 2'b00; we = 2'b00;
      addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({gnt, done, ram_cs, ram_we, busy} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: gnt=%b done=%b cs=%b we=%b busy=%b want all 0",
                  gnt, done, ram_cs, ram_we, busy);
      end
      checks++;
      if ({ram_addr, ram_wdata} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_ram_bus: addr=%h wdata=%h want 00 00", ram_addr, ram_wdata);
      end
      checks++;
      if ({rdata0, rdata1} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_rdata: rdata0=%h rdata1=%h want 00 00", rdata0, rdata1);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy: busy=%b want 0", busy);
      end
   endtask

   task automatic test_write_read();
      bit ok, ok2;
      int g, c, d;
      clear_logs();
      push_exp(0, 1'b1, 8'h00);
      access(0, 1'b1, 8'h10, 8'hA5, ok);
      wait_done(done_cnt + 1, ok2);
      checks++;
      if (!(ok && ok2)) begin
         errors++;
         $display("FAIL wr_handshake: gnt_ok=%b done_ok=%b want 1 1", ok, ok2);
      end
      g = (gnt_cyc.size() > 0) ? gnt_cyc[0] : -100;
      c = (cs_cyc.size() > 0) ? cs_cyc[0] : -50;
      d = (done_cyc.size() > 0) ? done_cyc[0] : -50;
      checks++;
      if ((c - g) !== 1 || (d - g) !== 2) begin
         errors++;
         $display("FAIL wr_latency: cs at +%0d done at +%0d want +1 +2", c - g, d - g);
      end
      checks++;
      if ({cs_we_last, cs_addr_last, cs_wdata_last} !== {1'b1, 8'h10, 8'hA5}) begin
         errors++;
         $display("FAIL wr_strobe: we=%b addr=%h wdata=%h want 1 10 a5",
                  cs_we_last, cs_addr_last, cs_wdata_last);
      end
      push_exp(0, 1'b0, 8'hA5);
      access(0, 1'b0, 8'h10, 8'h00, ok);
      wait_done(done_cnt + 1, ok2);
      checks++;
      if (!(ok && ok2) || rdata0 !== 8'hA5 || rdata1 !== 8'h00) begin
         errors++;
         $display("FAIL rd_back: ok=%b%b rdata0=%h rdata1=%h want 11 a5 00",
                  ok, ok2, rdata0, rdata1);
      end
   endtask

   task automatic preload(input int p, input logic [7:0] a, input logic [7:0] d);
      bit ok, ok2;
      push_exp(p, 1'b1, 8'h00);
      access(p, 1'b1, a, d, ok);
      wait_done(done_cnt + 1, ok2);
      checks++;
      if (!(ok && ok2)) begin
         errors++;
         $display("FAIL preload_%h: gnt_ok=%b done_ok=%b want 1 1", a, ok, ok2);
      end
   endtask

   // both ports request in the same cycle; fixed priority serves the probe first,
   // round-robin from reset (last winner = probe) serves the cpu first
   task automatic test_contention();
      bit ok;
      int first, base, g0, g1, d1;
      logic [1:0] hit;
`ifdef MEM_ARB_RR_EN
      first = 0;
`else
      first = 1;
`endif
      apply_reset();
      clear_logs();
      base = done_cnt;
      push_exp(first, 1'b0, first ? 8'hC3 : 8'h3C);
      push_exp(1 - first, 1'b0, first ? 8'h3C : 8'hC3);
      @(posedge clk); #1;
      we = 2'b00; addr0 = 8'h20; addr1 = 8'h21; req = 2'b11;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         hit = gnt;
         @(posedge clk); #1;
         req = req & ~hit;
         if (req == 2'b00) break;
      end
      req = 2'b00;
      wait_done(base + 2, ok);
      g0 = (gnt_cyc.size() > 1) ? gnt_cyc[0] : -100;
      g1 = (gnt_cyc.size() > 1) ? gnt_cyc[1] : -50;
      d1 = (done_cyc.size() > 1) ? done_cyc[1] : -50;
      checks++;
      if (!ok || gnt_port.size() != 2 || gnt_port[0] != first) begin
         errors++;
         $display("FAIL contention_order: done_ok=%b grants=%0d first=%0d want 1 2 %0d",
                  ok, gnt_port.size(), (gnt_port.size() > 0) ? gnt_port[0] : -1, first);
      end
      checks++;
      if ((g1 - g0) !== 3 || (d1 - g0) !== 5) begin
         errors++;
         $display("FAIL contention_timing: 2nd gnt +%0d last done +%0d want +3 +5",
                  g1 - g0, d1 - g0);
      end
      checks++;
      if (rdata0 !== 8'h3C || rdata1 !== 8'hC3) begin
         errors++;
         $display("FAIL contention_rdata: rdata0=%h rdata1=%h want 3c c3", rdata0, rdata1);
      end
   endtask

   task automatic test_hold_both();
      bit ok;
      int n, base;
      int exp_port[4];
`ifdef MEM_ARB_RR_EN
      exp_port = '{0, 1, 0, 1};
`else
      exp_port = '{1, 1, 1, 1};
`endif
      apply_reset();
      clear_logs();
      base = done_cnt;
      for (int k = 0; k < 4; k++)
         push_exp(exp_port[k], 1'b0, exp_port[k] ? 8'hC3 : 8'h3C);
      @(posedge clk); #1;
      we = 2'b00; addr0 = 8'h20; addr1 = 8'h21; req = 2'b11;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (gnt != 2'b00) n++;
         @(posedge clk); #1;
         if (n >= 4) break;
      end
      req = 2'b00;
      wait_done(base + 4, ok);
      checks++;
      if (!ok || gnt_port.size() != 4) begin
         errors++;
         $display("FAIL hold_both_count: done_ok=%b grants=%0d want 1 4", ok, gnt_port.size());
      end
      for (int k = 0; k < 4; k++) begin
         if (k < gnt_port.size()) begin
            checks++;
            if (gnt_port[k] != exp_port[k]) begin
               errors++;
               $display("FAIL hold_both_grant%0d: port %0d want %0d", k, gnt_port[k], exp_port[k]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int n, base;
      preload(0, 8'h00, 8'h11);
      preload(1, 8'h01, 8'h22);
      preload(0, 8'h02, 8'h33);
      clear_logs();
      base = done_cnt;
      push_exp(0, 1'b0, 8'h11);
      push_exp(0, 1'b0, 8'h22);
      push_exp(0, 1'b0, 8'h33);
      @(posedge clk); #1;
      drive_req(0, 1'b0, 8'h00, 8'h00);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (gnt[0]) n++;
         @(posedge clk); #1;
         if (n >= 3) break;
         addr0 = n[7:0];
      end
      req[0] = 1'b0;
      wait_done(base + 3, ok);
      checks++;
      if (!ok || gnt_cyc.size() != 3 || cs_cyc.size() != 3) begin
         errors++;
         $display("FAIL b2b_count: done_ok=%b grants=%0d strobes=%0d want 1 3 3",
                  ok, gnt_cyc.size(), cs_cyc.size());
      end
      if (gnt_cyc.size() == 3 && cs_cyc.size() == 3) begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (cs_cyc[k] - gnt_cyc[k] != 1 || (k > 0 && gnt_cyc[k] - gnt_cyc[k-1] != 3)) begin
               errors++;
               $display("FAIL b2b_spacing%0d: gnt at %0d cs at %0d prev gnt %0d want cs=gnt+1 gap 3",
                        k, gnt_cyc[k], cs_cyc[k], (k > 0) ? gnt_cyc[k-1] : gnt_cyc[k] - 3);
            end
         end
      end
   endtask

   // reset lands while the write strobe is on the RAM pins, so the RAM still samples it
   task automatic test_reset_mid();
      bit ok, ok2;
      int base;
      clear_logs();
      base = done_cnt;
      @(posedge clk); #1;
      drive_req(0, 1'b1, 8'h30, 8'h5A);
      wait_gnt(0, ok);
      @(posedge clk); #1;
      req = 2'b00;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ram_cs !== 1'b1 || !ok) begin
         errors++;
         $display("FAIL midrst_access: gnt_ok=%b cs=%b want 1 1", ok, ram_cs);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ram_cs !== 1'b0 || done !== 2'b00) begin
         errors++;
         $display("FAIL midrst_abort: busy=%b cs=%b done=%b want 0 0 00", busy, ram_cs, done);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (done_cnt != base || cs_cyc.size() != 1) begin
         errors++;
         $display("FAIL midrst_quiet: dones=%0d strobes=%0d want 0 1",
                  done_cnt - base, cs_cyc.size());
      end
      push_exp(0, 1'b0, 8'h5A);
      access(0, 1'b0, 8'h30, 8'h00, ok);
      wait_done(base + 1, ok2);
      checks++;
      if (!(ok && ok2) || rdata0 !== 8'h5A) begin
         errors++;
         $display("FAIL midrst_reread: ok=%b%b rdata0=%h want 11 5a", ok, ok2, rdata0);
      end
   endtask

   task automatic test_withdrawn();
      bit ok, ok2;
      int base;
      clear_logs();
      base = done_cnt;
      push_exp(0, 1'b0, 8'h11);
      @(posedge clk); #1;
      drive_req(0, 1'b0, 8'h00, 8'h00);
      wait_gnt(0, ok);
      @(posedge clk); #1;
      req[0] = 1'b0;
      drive_req(1, 1'b1, 8'h40, 8'hFF);
      @(posedge clk); #1;
      req[1] = 1'b0;
      wait_done(base + 1, ok2);
      @(negedge clk);
      checks++;
      if (!(ok && ok2) || busy !== 1'b0 || gnt !== 2'b00) begin
         errors++;
         $display("FAIL withdrawn_idle: ok=%b%b busy=%b gnt=%b want 11 0 00", ok, ok2, busy, gnt);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (gnt_port.size() != 1 || cs_cyc.size() != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL withdrawn_side_effect: grants=%0d strobes=%0d busy=%b want 1 1 0",
                  gnt_port.size(), cs_cyc.size(), busy);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      preload(0, 8'h20, 8'h3C);
      preload(1, 8'h21, 8'hC3);
      test_contention();
      test_hold_both();
      test_back_to_back();
      test_reset_mid();
      test_withdrawn();
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d expected completions never seen, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
